// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the inst SRAM handshake,
// buffers one instruction for decode and squashes redirected responses.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned EXC_W    = 5,
  parameter logic [EXC_W-1:0] EXC_ADEL = 5'h04
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             id_allowin,
  output logic             inst_sram_req,
  output logic [31:0]      inst_sram_addr,
  input  logic             inst_sram_addr_ok,
  input  logic             inst_sram_rrdy,
  input  logic [31:0]      inst_sram_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic [EXC_W-1:0] if_exc
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_CANCEL = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nx;
  logic               r_pend;
  logic               w_pend_nx;
  logic [31:0]        r_pend_pc;
  logic [31:0]        w_pend_pc_nx;

  logic               r_if_valid;
  logic [31:0]        r_if_pc;
  logic [31:0]        r_if_inst;
  logic [EXC_W-1:0]   r_if_exc;

  logic               w_bad;
  logic               w_ld;
  logic [31:0]        w_ld_inst;
  logic [EXC_W-1:0]   w_ld_exc;
  logic               w_clr;

  assign w_bad = ~r_pc[31] | (|r_pc[1:0]);

  // resetn gates req so the bus sees no request while reset is held
  assign inst_sram_req  = resetn & (r_state == S_REQ) & ~w_bad;
  assign inst_sram_addr = r_pc;

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_exc   = r_if_exc;

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_pend_nx    = r_pend;
    w_pend_pc_nx = r_pend_pc;
    w_ld         = 1'b0;
    w_ld_inst    = '0;
    w_ld_exc     = '0;
    w_clr        = redirect_valid;
    unique case (r_state)
      S_REQ: begin
        if (w_bad) begin
          if (redirect_valid) begin
            w_pc_nx = redirect_pc;
          end else begin
            w_ld       = 1'b1;
            w_ld_exc   = EXC_ADEL;
            w_state_nx = S_FAULT;
          end
        end else if (inst_sram_addr_ok) begin
          w_pend_nx = 1'b0;
          if (redirect_valid) begin
            w_pc_nx    = redirect_pc;
            w_state_nx = S_CANCEL;
          end else if (r_pend) begin
            w_pc_nx    = r_pend_pc;
            w_state_nx = S_CANCEL;
          end else begin
            w_state_nx = S_WAIT;
          end
        end else if (redirect_valid) begin
          // request already on the bus: keep addr stable, remember target
          w_pend_nx    = 1'b1;
          w_pend_pc_nx = redirect_pc;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nx    = redirect_pc;
          w_state_nx = inst_sram_rrdy ? S_REQ : S_CANCEL;
        end else if (inst_sram_rrdy) begin
          w_ld       = 1'b1;
          w_ld_inst  = inst_sram_rdata;
          w_pc_nx    = r_pc + 32'd4;
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nx    = redirect_pc;
          w_state_nx = S_REQ;
        end else if (id_allowin) begin
          w_clr      = 1'b1;
          w_state_nx = S_REQ;
        end
      end
      S_CANCEL: begin
        if (redirect_valid) w_pc_nx = redirect_pc;
        if (inst_sram_rrdy) w_state_nx = S_REQ;
      end
      S_FAULT: begin
        if (redirect_valid) begin
          w_pc_nx    = redirect_pc;
          w_state_nx = S_REQ;
        end else if (id_allowin) begin
          w_clr = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_pend    <= w_pend_nx;
      r_pend_pc <= w_pend_pc_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_exc   <= '0;
    end else if (w_ld) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_pc;
      r_if_inst  <= w_ld_inst;
      r_if_exc   <= w_ld_exc;
    end else if (w_clr) begin
      r_if_valid <= 1'b0;
    end
  end

endmodule
